// File: rtl/hid_report_sniffer.sv
// HID keyboard report sniffer: captures IN reports and LED OUT reports, detects key press edges and
// runs a press-count ownership FSM. Define HID_SNIFF_LED_GATE_EN to gate COUNT->OWNED on the Caps LED.
module hid_report_sniffer #(
  parameter int          DATA_W       = 64,
  parameter int          KEY_SLOTS    = 6,
  parameter int          LED_W        = 4,
  parameter int          EP_NUM       = 0,
  parameter logic [7:0]  TRIG_KEY     = 8'h39,
  parameter int          TRIG_PRESSES = 3,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd12_000_000,
  parameter logic [7:0]  EXIT_KEY     = 8'h29,
  parameter logic [7:0]  EXIT_MOD     = 8'h05
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        usb_state,
  input  logic [7:0]        pid,
  output logic [7:0]        modifier,
  output logic [7:0]        keycode,
  output logic [LED_W-1:0]  leds,
  output logic              key_event,
  output logic [7:0]        key_event_code,
  output logic              owned,
  output logic [DATA_W-1:0] own_data,
  output logic [1:0]        state_dbg
);

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  localparam logic [2:0] PKT_DONE  = 3'd4;
  localparam logic [3:0] EP_MATCH  = EP_NUM[3:0];
  localparam logic [3:0] TRIG_CNT  = TRIG_PRESSES[3:0];

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_OWNED  = 2'd2;

  logic [7:0]        prev_pid_q, prev_pid_d;
  logic              led_pending_q, led_pending_d;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic [DATA_W-1:0] report_q, report_d;
  logic [7:0]        modifier_q, modifier_d;
  logic [7:0]        keycode_q, keycode_d;
  logic              key_event_q, key_event_d;
  logic [7:0]        key_event_code_q, key_event_code_d;
  logic [DATA_W-1:0] own_data_q, own_data_d;
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [23:0]       timer_q, timer_d;

  logic              pkt;
  logic              is_data_pid;
  logic              led_wr;
  logic              capture;
  logic              gate_ok;

  logic [7:0]        new_code;
  logic              in_old;
  logic              edge_found;
  logic [7:0]        edge_code;
  logic              trig_hit;
  logic              other_hit;
  logic              exit_key_seen;
  logic              first_found;
  logic [7:0]        first_code;

  logic              trig_ev;
  logic              other_ev;
  logic              exit_ev;

  assign pkt         = (usb_state == PKT_DONE);
  assign is_data_pid = (pid == PID_DATA0) || (pid == PID_DATA1);
  assign led_wr      = pkt && is_data_pid && led_pending_q;
  assign capture     = pkt && is_data_pid && (prev_pid_q == PID_IN) && !led_pending_q;

`ifdef HID_SNIFF_LED_GATE_EN
  assign gate_ok = leds_q[1];
`else
  assign gate_ok = 1'b1;
`endif

  // The stored report is the "previous" report at capture time; edges compare the incoming slots to it.
  always_comb begin
    new_code      = '0;
    in_old        = 1'b0;
    edge_found    = 1'b0;
    edge_code     = '0;
    trig_hit      = 1'b0;
    other_hit     = 1'b0;
    exit_key_seen = 1'b0;
    first_found   = 1'b0;
    first_code    = '0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      new_code = data[16 + 8*i +: 8];
      in_old   = 1'b0;
      for (int j = 0; j < KEY_SLOTS; j++) begin
        if (report_q[16 + 8*j +: 8] == new_code) begin
          in_old = 1'b1;
        end
      end
      if ((new_code != 8'd0) && !in_old) begin
        if (!edge_found) begin
          edge_found = 1'b1;
          edge_code  = new_code;
        end
        if (new_code == TRIG_KEY) begin
          trig_hit = 1'b1;
        end else begin
          other_hit = 1'b1;
        end
      end
      if ((new_code != 8'd0) && !first_found) begin
        first_found = 1'b1;
        first_code  = new_code;
      end
      if (new_code == EXIT_KEY) begin
        exit_key_seen = 1'b1;
      end
    end
  end

  assign trig_ev  = capture && trig_hit;
  assign other_ev = capture && other_hit;
  assign exit_ev  = capture && exit_key_seen && (data[7:0] == EXIT_MOD);

  always_comb begin
    prev_pid_d       = pkt ? pid : prev_pid_q;
    led_pending_d    = pkt ? ((pid == PID_OUT) && (data[10:7] == EP_MATCH)) : led_pending_q;
    leds_d           = led_wr ? data[LED_W-1:0] : leds_q;
    report_d         = capture ? data : report_q;
    modifier_d       = capture ? data[7:0] : modifier_q;
    keycode_d        = capture ? first_code : keycode_q;
    key_event_d      = capture && edge_found;
    key_event_code_d = (capture && edge_found) ? edge_code : key_event_code_q;
  end

  // An edge in the same cycle as timer expiry still counts; the window is not reloaded by later presses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_ev) begin
          cnt_d   = 4'd1;
          timer_d = TIMEOUT_CYC;
          state_d = ((TRIG_CNT <= 4'd1) && gate_ok) ? ST_OWNED : ST_COUNT;
        end
      end
      ST_COUNT: begin
        timer_d = (timer_q != 24'd0) ? (timer_q - 24'd1) : 24'd0;
        if (trig_ev && (cnt_q != 4'hF)) begin
          cnt_d = cnt_q + 4'd1;
        end
        if ((cnt_d >= TRIG_CNT) && gate_ok) begin
          state_d = ST_OWNED;
          timer_d = 24'd0;
        end else if (other_ev) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          timer_d = 24'd0;
        end else if (!trig_ev && (timer_q <= 24'd1)) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          timer_d = 24'd0;
        end
      end
      ST_OWNED: begin
        if (exit_ev) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          timer_d = 24'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        timer_d = 24'd0;
      end
    endcase
  end

  always_comb begin
    own_data_d = (state_d == ST_OWNED) ? '0 : report_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pid_q       <= '0;
      led_pending_q    <= 1'b0;
      leds_q           <= '0;
      report_q         <= '0;
      modifier_q       <= '0;
      keycode_q        <= '0;
      key_event_q      <= 1'b0;
      key_event_code_q <= '0;
      own_data_q       <= '0;
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      timer_q          <= '0;
    end else begin
      prev_pid_q       <= prev_pid_d;
      led_pending_q    <= led_pending_d;
      leds_q           <= leds_d;
      report_q         <= report_d;
      modifier_q       <= modifier_d;
      keycode_q        <= keycode_d;
      key_event_q      <= key_event_d;
      key_event_code_q <= key_event_code_d;
      own_data_q       <= own_data_d;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      timer_q          <= timer_d;
    end
  end

  assign modifier       = modifier_q;
  assign keycode        = keycode_q;
  assign leds           = leds_q;
  assign key_event      = key_event_q;
  assign key_event_code = key_event_code_q;
  assign owned          = (state_q == ST_OWNED);
  assign own_data       = own_data_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_hid_report_sniffer.sv
// Directed bench for hid_report_sniffer: a table of report/LED vectors followed by hand-written
// sequences for timeout, duplicate reports, LED gating and mid-packet reset.
module tb_hid_report_sniffer;

  localparam int DATA_W = 64;
  localparam int LED_W  = 4;

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [2:0]        usb_state = 3'd0;
  logic [7:0]        pid = 8'h00;
  logic [7:0]        modifier;
  logic [7:0]        keycode;
  logic [LED_W-1:0]  leds;
  logic              key_event;
  logic [7:0]        key_event_code;
  logic              owned;
  logic [DATA_W-1:0] own_data;
  logic [1:0]        state_dbg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          isLed;
    logic [63:0] data;
    logic [7:0]  expMod;
    logic [7:0]  expKey;
    logic        expEv;
    logic [7:0]  expCode;
    logic [1:0]  expState;
    logic [3:0]  expLeds;
    logic [63:0] expOwn;
  } vec_t;

  vec_t vecs[17];

  hid_report_sniffer #(
    .DATA_W(DATA_W),
    .KEY_SLOTS(6),
    .LED_W(LED_W),
    .EP_NUM(0),
    .TRIG_KEY(8'h39),
    .TRIG_PRESSES(3),
    .TIMEOUT_CYC(24'd40),
    .EXIT_KEY(8'h29),
    .EXIT_MOD(8'h05)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .usb_state(usb_state),
    .pid(pid),
    .modifier(modifier),
    .keycode(keycode),
    .leds(leds),
    .key_event(key_event),
    .key_event_code(key_event_code),
    .owned(owned),
    .own_data(own_data),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkR(input logic [7:0] m, input logic [7:0] k0, input logic [7:0] k1);
    logic [63:0] r;
    r        = 64'h0;
    r[7:0]   = m;
    r[23:16] = k0;
    r[31:24] = k1;
    return r;
  endfunction

  function automatic vec_t mkVec(input bit isLed, input logic [63:0] d, input logic [7:0] eMod,
                                 input logic [7:0] eKey, input logic eEv, input logic [7:0] eCode,
                                 input logic [1:0] eState, input logic [3:0] eLeds, input logic [63:0] eOwn);
    vec_t v;
    v.isLed    = isLed;
    v.data     = d;
    v.expMod   = eMod;
    v.expKey   = eKey;
    v.expEv    = eEv;
    v.expCode  = eCode;
    v.expState = eState;
    v.expLeds  = eLeds;
    v.expOwn   = eOwn;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sendPacket(input logic [7:0] p, input logic [63:0] d);
    @(negedge clk);
    usb_state = 3'd4;
    pid       = p;
    data      = d;
    @(negedge clk);
    usb_state = 3'd0;
    pid       = 8'h00;
    data      = '0;
  endtask

  task automatic sendReport(input logic [63:0] d);
    sendPacket(PID_IN, 64'h0);
    sendPacket(PID_DATA0, d);
  endtask

  task automatic sendLed(input logic [63:0] d);
    sendPacket(PID_OUT, 64'h0);
    sendPacket(PID_DATA1, d);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isLed) sendLed(v.data);
    else sendReport(v.data);
  endtask

  task automatic checkState(input string name, input logic [1:0] exp);
    checkOutput({name, "_state"}, {62'd0, state_dbg}, {62'd0, exp});
    checkOutput({name, "_owned"}, {63'd0, owned}, {63'd0, (exp == 2'd2)});
  endtask

  task automatic checkVec(input int i, input vec_t v);
    string n;
    n = $sformatf("v%0d", i);
    checkOutput({n, "_modifier"}, {56'd0, modifier}, {56'd0, v.expMod});
    checkOutput({n, "_keycode"}, {56'd0, keycode}, {56'd0, v.expKey});
    checkOutput({n, "_key_event"}, {63'd0, key_event}, {63'd0, v.expEv});
    checkOutput({n, "_event_code"}, {56'd0, key_event_code}, {56'd0, v.expCode});
    checkOutput({n, "_leds"}, {60'd0, leds}, {60'd0, v.expLeds});
    checkOutput({n, "_own_data"}, own_data, v.expOwn);
    checkState(n, v.expState);
  endtask

  initial begin
    vecs[0]  = mkVec(0, mkR(8'h00, 8'h04, 8'h00), 8'h00, 8'h04, 1, 8'h04, 2'd0, 4'h0, mkR(8'h00, 8'h04, 8'h00));
    vecs[1]  = mkVec(1, 64'h2,                    8'h00, 8'h04, 0, 8'h04, 2'd0, 4'h2, mkR(8'h00, 8'h04, 8'h00));
    vecs[2]  = mkVec(0, mkR(8'h00, 8'h00, 8'h00), 8'h00, 8'h00, 0, 8'h04, 2'd0, 4'h2, 64'h0);
    vecs[3]  = mkVec(0, mkR(8'h00, 8'h39, 8'h00), 8'h00, 8'h39, 1, 8'h39, 2'd1, 4'h2, mkR(8'h00, 8'h39, 8'h00));
    vecs[4]  = mkVec(0, mkR(8'h00, 8'h00, 8'h00), 8'h00, 8'h00, 0, 8'h39, 2'd1, 4'h2, 64'h0);
    vecs[5]  = mkVec(0, mkR(8'h00, 8'h39, 8'h00), 8'h00, 8'h39, 1, 8'h39, 2'd1, 4'h2, mkR(8'h00, 8'h39, 8'h00));
    vecs[6]  = mkVec(0, mkR(8'h00, 8'h00, 8'h00), 8'h00, 8'h00, 0, 8'h39, 2'd1, 4'h2, 64'h0);
    vecs[7]  = mkVec(0, mkR(8'h00, 8'h39, 8'h00), 8'h00, 8'h39, 1, 8'h39, 2'd2, 4'h2, 64'h0);
    vecs[8]  = mkVec(0, mkR(8'h05, 8'h29, 8'h00), 8'h05, 8'h29, 1, 8'h29, 2'd0, 4'h2, mkR(8'h05, 8'h29, 8'h00));
    vecs[9]  = mkVec(0, mkR(8'h00, 8'h04, 8'h05), 8'h00, 8'h04, 1, 8'h04, 2'd0, 4'h2, mkR(8'h00, 8'h04, 8'h05));
    vecs[10] = mkVec(0, mkR(8'h00, 8'h05, 8'h04), 8'h00, 8'h05, 0, 8'h04, 2'd0, 4'h2, mkR(8'h00, 8'h05, 8'h04));
    vecs[11] = mkVec(0, mkR(8'h00, 8'h00, 8'h05), 8'h00, 8'h05, 0, 8'h04, 2'd0, 4'h2, mkR(8'h00, 8'h00, 8'h05));
    vecs[12] = mkVec(0, mkR(8'h00, 8'h00, 8'h05), 8'h00, 8'h05, 0, 8'h04, 2'd0, 4'h2, mkR(8'h00, 8'h00, 8'h05));
    vecs[13] = mkVec(0, mkR(8'h00, 8'h00, 8'h06), 8'h00, 8'h06, 1, 8'h06, 2'd0, 4'h2, mkR(8'h00, 8'h00, 8'h06));
    vecs[14] = mkVec(0, mkR(8'h00, 8'h39, 8'h00), 8'h00, 8'h39, 1, 8'h39, 2'd1, 4'h2, mkR(8'h00, 8'h39, 8'h00));
    vecs[15] = mkVec(0, mkR(8'h00, 8'h39, 8'h07), 8'h00, 8'h39, 1, 8'h07, 2'd0, 4'h2, mkR(8'h00, 8'h39, 8'h07));
    vecs[16] = mkVec(0, mkR(8'h00, 8'h00, 8'h00), 8'h00, 8'h00, 0, 8'h07, 2'd0, 4'h2, 64'h0);

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_modifier", {56'd0, modifier}, 64'h0);
    checkOutput("rst_keycode", {56'd0, keycode}, 64'h0);
    checkOutput("rst_leds", {60'd0, leds}, 64'h0);
    checkOutput("rst_key_event", {63'd0, key_event}, 64'h0);
    checkOutput("rst_own_data", own_data, 64'h0);
    checkState("rst", 2'd0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkVec(i, vecs[i]);
    end

    // Two presses then window expiry, then a fresh count of three
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkState("to_p1", 2'd1);
    sendReport(64'h0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkState("to_p2", 2'd1);
    sendReport(64'h0);
    repeat (50) @(negedge clk);
    checkState("to_expired", 2'd0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkState("to_restart1", 2'd1);
    sendReport(64'h0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkState("to_restart2", 2'd1);
    sendReport(64'h0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkState("to_restart3", 2'd2);
    checkOutput("to_own_zero", own_data, 64'h0);
    sendReport(mkR(8'h01, 8'h29, 8'h00));
    checkState("wrong_mod", 2'd2);
    checkOutput("wrong_mod_own", own_data, 64'h0);
    checkOutput("wrong_mod_modifier", {56'd0, modifier}, 64'h01);
    sendReport(mkR(8'h05, 8'h29, 8'h00));
    checkState("exit_held_key", 2'd0);
    checkOutput("exit_held_key_ev", {63'd0, key_event}, 64'h0);
    checkOutput("exit_own_mirror", own_data, mkR(8'h05, 8'h29, 8'h00));

    // Duplicate reports of the trigger key give one edge and never reach OWNED
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkOutput("dup1_ev", {63'd0, key_event}, 64'h1);
    checkState("dup1", 2'd1);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkOutput("dup2_ev", {63'd0, key_event}, 64'h0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    checkOutput("dup3_ev", {63'd0, key_event}, 64'h0);
    checkState("dup3", 2'd1);
    repeat (50) @(negedge clk);
    checkState("dup_expired", 2'd0);

    // OUT on another endpoint is ignored; then Caps LED cleared before three presses
    sendPacket(PID_OUT, 64'h180);
    sendPacket(PID_DATA1, 64'hF);
    checkOutput("ep_mismatch_leds", {60'd0, leds}, 64'h2);
    checkOutput("ep_mismatch_keycode", {56'd0, keycode}, 64'h39);
    sendLed(64'h0);
    checkOutput("led_clear", {60'd0, leds}, 64'h0);
    sendReport(64'h0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    sendReport(64'h0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
    sendReport(64'h0);
    sendReport(mkR(8'h00, 8'h39, 8'h00));
`ifdef HID_SNIFF_LED_GATE_EN
    checkState("gate_unlit", 2'd1);
`else
    checkState("gate_unlit", 2'd2);
`endif
    sendLed(64'h2);
    @(negedge clk);
    checkState("gate_lit", 2'd2);
    sendReport(mkR(8'h05, 8'h29, 8'h00));
    checkState("gate_exit", 2'd0);

    // Reset asserted while a DATA0 capture is on the bus
    sendPacket(PID_IN, 64'h0);
    @(negedge clk);
    usb_state = 3'd4;
    pid       = PID_DATA0;
    data      = mkR(8'h00, 8'h11, 8'h00);
    rst_n     = 1'b0;
    #1;
    checkOutput("midrst_modifier", {56'd0, modifier}, 64'h0);
    checkOutput("midrst_keycode", {56'd0, keycode}, 64'h0);
    checkOutput("midrst_leds", {60'd0, leds}, 64'h0);
    checkOutput("midrst_code", {56'd0, key_event_code}, 64'h0);
    checkOutput("midrst_own", own_data, 64'h0);
    checkState("midrst", 2'd0);
    @(negedge clk);
    usb_state = 3'd0;
    pid       = 8'h00;
    data      = '0;
    rst_n     = 1'b1;
    sendReport(mkR(8'h00, 8'h29, 8'h00));
    checkOutput("postrst_ev", {63'd0, key_event}, 64'h1);
    checkOutput("postrst_code", {56'd0, key_event_code}, 64'h29);
    checkOutput("postrst_keycode", {56'd0, keycode}, 64'h29);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
